// File: rtl/gain_ramp_ctrl.sv
// Gain ramp sequencer for the fixed-point audio gain datapath.
// Takes target gains over valid/ready, ramps the applied gain one step per
// sample strobe, provides a click-free soft mute and a unity-only bypass.
module gain_ramp_ctrl #(
    parameter int GWIDTH = 16,
    parameter int FBITS  = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     tgt_valid,
    output logic                     tgt_ready,
    input  logic signed [GWIDTH-1:0] tgt_gain,
    input  logic        [GWIDTH-2:0] step,
    input  logic                     mute,
    input  logic                     bypass_req,
    output logic signed [GWIDTH-1:0] gain_o,
    output logic                     en_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     mute_ack_o
);

    localparam logic [GWIDTH-1:0] UNITY = {{(GWIDTH-1){1'b0}}, 1'b1} << FBITS;

    typedef enum logic [1:0] {IDLE, RAMP, MUTED} state_t;

    state_t            state, next_state;
    logic [GWIDTH-1:0] tgt_reg, next_tgt;
    logic [GWIDTH-1:0] next_gain;
    logic              next_done;
    logic              next_en;
    logic              accept;
    logic [GWIDTH-1:0] eff;
    logic [GWIDTH:0]   diff;
    logic [GWIDTH:0]   abs_diff;
    logic [GWIDTH:0]   step_ext;
    logic [GWIDTH-1:0] stepped;

    assign tgt_ready = (state == IDLE) && !mute;
    assign accept    = tgt_valid && tgt_ready;

    // One ramp step toward the effective target, clamping onto it when close enough.
    always_comb begin
        eff      = mute ? '0 : tgt_reg;
        diff     = {eff[GWIDTH-1], eff} - {gain_o[GWIDTH-1], gain_o};
        abs_diff = diff[GWIDTH] ? (~diff + 1'b1) : diff;
        step_ext = {2'b00, step};
        stepped  = eff;
        if (step != '0 && abs_diff > step_ext) begin
            if (diff[GWIDTH])
                stepped = gain_o - {1'b0, step};
            else
                stepped = gain_o + {1'b0, step};
        end
    end

    // Next-state, next-gain and next-output decisions for the IDLE/RAMP/MUTED machine.
    always_comb begin
        next_state = state;
        next_gain  = gain_o;
        next_tgt   = tgt_reg;
        next_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (mute) begin
                    next_state = (gain_o == '0) ? MUTED : RAMP;
                end else if (accept) begin
                    next_tgt = tgt_gain;
                    if (tgt_gain == gain_o)
                        next_done = 1'b1;
                    else
                        next_state = RAMP;
                end
            end
            RAMP: begin
                if (ce) begin
                    next_gain = stepped;
                    if (stepped == eff) begin
                        if (mute) begin
                            next_state = MUTED;
                        end else begin
                            next_state = IDLE;
                            next_done  = 1'b1;
                        end
                    end
                end
            end
            MUTED: begin
                next_gain = '0;
                if (!mute)
                    next_state = RAMP;
            end
            default: next_state = IDLE;
        endcase
        next_en = !(bypass_req && (next_state == IDLE) && (next_gain == UNITY) && !mute);
    end

    // Registered state and outputs; reset discards any target and mute progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gain_o     <= UNITY;
            tgt_reg    <= UNITY;
            en_o       <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            mute_ack_o <= 1'b0;
        end else begin
            state      <= next_state;
            gain_o     <= next_gain;
            tgt_reg    <= next_tgt;
            en_o       <= next_en;
            busy_o     <= (next_state == RAMP);
            done_o     <= next_done;
            mute_ack_o <= (next_state == MUTED);
        end
    end

endmodule
